// File: rtl/cam_row_packer.sv
// Packs a camera pixel stream into ROW_PIX-pixel row words, framed by SOF,
// and presents each word to the PE array over a valid/ready handshake.
module cam_row_packer #(
  parameter int PIX_W   = 8,
  parameter int ROW_PIX = 26,
  parameter int ROWS    = 26
) (
  input  logic                       camclk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [PIX_W-1:0]           i_pix,
  input  logic                       i_pix_valid,
  input  logic                       i_sof,
  output logic [PIX_W*ROW_PIX-1:0]   o_parallel_data,
  output logic                       o_row_valid,
  input  logic                       i_row_ready,
  output logic [$clog2(ROWS)-1:0]    o_row_idx,
  output logic                       o_frame_end,
  output logic                       o_overflow,
  output logic                       o_frame_err
);

  localparam int WORD_W = PIX_W * ROW_PIX;
  localparam int COL_W  = $clog2(ROW_PIX);
  localparam int ROW_W  = $clog2(ROWS);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [WORD_W-1:0]   asm_q, asm_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [ROW_W-1:0]    idx_q, idx_d;
  logic                end_q, end_d;
  logic                ovf_q, ovf_d;
  logic                ferr_q, ferr_d;

  logic pix_take;
  logic row_done;
  logic drain;
  logic load;

  assign pix_take = en & i_pix_valid;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    asm_d    = asm_q;
    row_done = 1'b0;
    if (!en) begin
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
    end else if (pix_take) begin
      if (i_sof) begin
        // SOF always restarts the frame; any partial row is abandoned.
        asm_d[PIX_W-1:0] = i_pix;
        state_d          = ACTIVE;
        col_d            = COL_W'(1);
        row_d            = '0;
      end else if (state_q == ACTIVE) begin
        asm_d[int'(col_q)*PIX_W +: PIX_W] = i_pix;
        if (col_q == COL_W'(ROW_PIX - 1)) begin
          row_done = 1'b1;
          col_d    = '0;
          if (row_q == ROW_W'(ROWS - 1)) begin
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  // The output register accepts a finished row only if empty or draining now.
  assign drain = valid_q & i_row_ready;
  assign load  = row_done & (~valid_q | drain);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    end_d   = end_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = asm_d;
      idx_d   = row_q;
      end_d   = (row_q == ROW_W'(ROWS - 1));
    end else if (drain) begin
      valid_d = 1'b0;
    end
    ovf_d  = ovf_q | (row_done & ~load);
    ferr_d = ferr_q | (pix_take & i_sof & (state_q == ACTIVE));
  end

  always_ff @(posedge camclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      end_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      end_q   <= end_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_parallel_data = data_q;
  assign o_row_valid     = valid_q;
  assign o_row_idx       = idx_q;
  assign o_frame_end     = end_q;
  assign o_overflow      = ovf_q;
  assign o_frame_err     = ferr_q;

endmodule

// File: tb/tb_cam_row_packer.sv
// Directed and randomized checks of cam_row_packer against a pixel-array
// reference model of framing, packing, handshake and sticky flags.
module tb_cam_row_packer;

  localparam int PIX_W   = 8;
  localparam int ROW_PIX = 26;
  localparam int ROWS    = 26;
  localparam int WW      = PIX_W * ROW_PIX;

  logic             camclk = 1'b0;
  logic             rst_n  = 1'b0;
  logic             en     = 1'b0;
  logic             pv     = 1'b0;
  logic             sof    = 1'b0;
  logic             ready  = 1'b0;
  logic [PIX_W-1:0] pix    = '0;

  logic [WW-1:0]    pdata;
  logic             rvalid;
  logic [4:0]       ridx;
  logic             fend;
  logic             ovf;
  logic             ferr;

  always #5 camclk = ~camclk;

  cam_row_packer #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .ROWS(ROWS)) dut (
    .camclk          (camclk),
    .rst_n           (rst_n),
    .en              (en),
    .i_pix           (pix),
    .i_pix_valid     (pv),
    .i_sof           (sof),
    .o_parallel_data (pdata),
    .o_row_valid     (rvalid),
    .i_row_ready     (ready),
    .o_row_idx       (ridx),
    .o_frame_end     (fend),
    .o_overflow      (ovf),
    .o_frame_err     (ferr)
  );

  int tests = 0;
  int fails = 0;
  int words = 0;

  // Reference model: pixel array of the row in progress plus the pending word.
  logic [PIX_W-1:0] cur [ROW_PIX];
  bit               m_active;
  int               m_col;
  int               m_row;
  bit               m_valid;
  logic [WW-1:0]    m_data;
  int               m_idx;
  bit               m_end;
  bit               m_ovf;
  bit               m_ferr;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_col = 0; m_row = 0;
    m_valid = 0; m_data = '0; m_idx = 0; m_end = 0;
    m_ovf = 0; m_ferr = 0;
  endtask

  task automatic model_step();
    bit            drain;
    bit            done;
    int            fin_row;
    logic [WW-1:0] w;
    drain   = m_valid && ready;
    done    = 0;
    fin_row = 0;
    w       = '0;
    if (!en) begin
      m_active = 0; m_col = 0; m_row = 0;
    end else if (pv) begin
      if (sof) begin
        if (m_active) m_ferr = 1;
        m_active = 1; cur[0] = pix; m_col = 1; m_row = 0;
      end else if (m_active) begin
        cur[m_col] = pix;
        m_col++;
        if (m_col == ROW_PIX) begin
          done = 1; fin_row = m_row; m_col = 0; m_row++;
          if (m_row == ROWS) begin
            m_row = 0; m_active = 0;
          end
        end
      end
    end
    if (done) begin
      for (int c = 0; c < ROW_PIX; c++) w[c*PIX_W +: PIX_W] = cur[c];
      if (!m_valid || drain) begin
        m_valid = 1; m_data = w; m_idx = fin_row; m_end = (fin_row == ROWS - 1);
      end else begin
        m_ovf = 1;
      end
    end else if (drain) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    check("row_valid", rvalid, m_valid);
    check("overflow", ovf, m_ovf);
    check("frame_err", ferr, m_ferr);
    if (m_valid) begin
      check("parallel_data", pdata, m_data);
      check("row_idx", ridx, m_idx);
      check("frame_end", fend, m_end);
    end
  endtask

  task automatic step(input bit v, input bit s, input logic [PIX_W-1:0] p, input bit r);
    pv = v; sof = s; pix = p; ready = r;
    if (rvalid && r) begin
      words++;
      $display("[TB] t=%0t word accepted idx=%0d frame_end=%0b", $time, ridx, fend);
    end
    @(posedge camclk);
    model_step();
    #1;
    compare_all();
  endtask

  function automatic bit pick_ready(input int rmode);
    if (rmode == 2) return bit'($urandom_range(0, 1));
    return bit'(rmode);
  endfunction

  // rmode: 0 ready low, 1 ready high, 2 random ready with random idle gaps.
  task automatic send_pixels(input int n, input bit sof_first, input int base,
                             input int rmode, input bit rnd);
    logic [PIX_W-1:0] val;
    for (int k = 0; k < n; k++) begin
      if (rmode == 2 && $urandom_range(0, 3) == 0) step(0, 0, '0, pick_ready(rmode));
      val = rnd ? PIX_W'($urandom) : PIX_W'((base + k) & 8'hFF);
      step(1, sof_first && (k == 0), val, pick_ready(rmode));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_valid", rvalid, 0);
    check("rst_data", pdata, 0);
    check("rst_idx", ridx, 0);
    check("rst_frame_end", fend, 0);
    check("rst_overflow", ovf, 0);
    check("rst_frame_err", ferr, 0);
    @(negedge camclk);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: full frame, ready always high, pixel = row + col
    do_reset();
    en = 1;
    for (int r = 0; r < ROWS; r++) send_pixels(ROW_PIX, r == 0, r, 1, 0);
    step(0, 0, '0, 1);
    check("t1_words", words, 26);

    // 2: backpressure causes overflow, then recovery
    send_pixels(ROW_PIX, 1, 0, 0, 1);
    send_pixels(ROW_PIX, 0, 0, 0, 1);
    check("t2_overflow", ovf, 1);
    check("t2_held_idx", ridx, 0);
    step(0, 0, '0, 1);
    check("t2_drained", rvalid, 0);
    send_pixels(ROW_PIX, 0, 0, 1, 1);
    check("t2_row2_idx", ridx, 2);
    for (int r = 3; r < ROWS; r++) send_pixels(ROW_PIX, 0, 0, 2, 1);
    step(0, 0, '0, 1);

    // 3: drain and completion in the same cycle
    do_reset();
    en = 1;
    send_pixels(ROW_PIX, 1, 0, 0, 1);
    send_pixels(ROW_PIX - 1, 0, 0, 0, 1);
    step(1, 0, PIX_W'($urandom), 1);
    check("t3_valid", rvalid, 1);
    check("t3_idx", ridx, 1);
    check("t3_no_overflow", ovf, 0);

    // 4: SOF in the middle of row 3
    send_pixels(ROW_PIX, 0, 0, 1, 1);
    send_pixels(10, 0, 0, 1, 1);
    send_pixels(ROW_PIX, 1, 0, 1, 1);
    check("t4_frame_err", ferr, 1);
    check("t4_idx", ridx, 0);
    check("t4_valid", rvalid, 1);

    // 5: en low with a word pending, then non-SOF pixels are ignored
    step(0, 0, '0, 1);
    send_pixels(ROW_PIX, 0, 0, 0, 1);
    send_pixels(5, 0, 0, 0, 1);
    en = 0;
    repeat (3) step(1, 0, PIX_W'($urandom), 0);
    check("t5_still_pending", rvalid, 1);
    step(0, 0, '0, 1);
    check("t5_drained", rvalid, 0);
    en = 1;
    repeat (30) step(1, 0, PIX_W'($urandom), 1);
    check("t5_ignored", rvalid, 0);
    send_pixels(ROW_PIX, 1, 0, 1, 1);
    check("t5_new_idx", ridx, 0);

    // 6: reset while a word is pending and flags are set
    send_pixels(ROW_PIX, 0, 0, 0, 1);
    send_pixels(7, 0, 0, 0, 1);
    check("t6_pre_ovf", ovf, 1);
    do_reset();
    en = 1;
    send_pixels(ROW_PIX, 1, 0, 1, 1);
    check("t6_new_idx", ridx, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 59) != 0);
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 699) == 0),
           PIX_W'($urandom), bit'($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
